instr_fetch_responder: RTL and testbench

Instruction-memory responder that serves the fetch side of the CPU state machine.
- The fetch FSM presents its program counter as a word address with a valid/ready request.
- This block returns the 32-bit instruction word after a programmable number of wait states, over a valid/ready response channel.
- A separate load port lets the bench or boot logic write program words into the internal memory.

---
 rtl/instr_fetch_responder.sv | 121 ++++++++++++
 tb/tb_instr_fetch_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_responder.sv
// Instruction-memory responder for the fetch FSM: valid/ready request in,
// instruction word out after WAIT_CYCLES wait states; separate load port.
module instr_fetch_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic [1:0]        state_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10,
    S_ILL  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic rd_in_range;
  logic ld_in_range;

  assign rd_in_range = {1'b0, addr_q} < DEPTH_L;
  assign ld_in_range = {1'b0, ld_addr} < DEPTH_L;

  // Memory has no reset so program words survive a CPU reset.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem_q[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  // Read is combinational off mem_q, so a same-edge load is seen next time.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (rd_in_range) begin
            instr_d = mem_q[addr_q[IDX_W-1:0]];
            err_d   = 1'b0;
          end else begin
            instr_d = NOP_WORD;
            err_d   = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_instr = instr_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign state_out = state_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench: default-latency instance (a) and WAIT_CYCLES=0 instance (b).
module tb_instr_fetch_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [15:0] a_req_addr, a_ld_addr;
  logic [31:0] a_rsp_instr, a_ld_data;
  logic        a_rsp_err, a_ld_en, a_busy;
  logic [1:0]  a_state;

  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [15:0] b_req_addr, b_ld_addr;
  logic [31:0] b_rsp_instr, b_ld_data;
  logic        b_rsp_err, b_ld_en, b_busy;
  logic [1:0]  b_state;

  instr_fetch_responder u_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_instr(a_rsp_instr), .rsp_err(a_rsp_err),
    .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data),
    .busy(a_busy), .state_out(a_state)
  );

  instr_fetch_responder #(.WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_instr(b_rsp_instr), .rsp_err(b_rsp_err),
    .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
    .busy(b_busy), .state_out(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [15:0] ad, input logic [31:0] d);
    a_ld_en = 1'b1; a_ld_addr = ad; a_ld_data = d;
    tick();
    a_ld_en = 1'b0;
  endtask

  task automatic load_b(input logic [15:0] ad, input logic [31:0] d);
    b_ld_en = 1'b1; b_ld_addr = ad; b_ld_data = d;
    tick();
    b_ld_en = 1'b0;
  endtask

  // Accept a request on dut a, then run the 3 wait edges into RESP.
  task automatic req_a(input logic [15:0] ad);
    a_req_valid = 1'b1; a_req_addr = ad;
    tick();
    a_req_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic hs_a();
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_chk++;
    if (a_state !== 2'b00 || a_req_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got st=%b rdy=%b busy=%b exp 00/1/0",
               a_state, a_req_ready, a_busy);
    end
    n_chk++;
    if (a_rsp_valid !== 1'b0 || a_rsp_instr !== 32'h0 || a_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp got v=%b i=%h e=%b exp 0/0/0",
               a_rsp_valid, a_rsp_instr, a_rsp_err);
    end
    n_chk++;
    if (b_state !== 2'b00 || b_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b got st=%b v=%b exp 00/0", b_state, b_rsp_valid);
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    logic [1:0] exp_st;
    load_a(16'd0, 32'hFFFF_FFFF);
    load_a(16'd1, 32'hAAAA_AAAA);
    load_a(16'd2, 32'hBBBB_BBBB);
    load_a(16'd44, 32'h4444_4444);
    a_req_valid = 1'b1; a_req_addr = 16'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      a_req_valid = 1'b0;
      exp_st = (i == 3) ? 2'b10 : 2'b01;
      n_chk++;
      if (a_state !== exp_st || a_rsp_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL fetch_seq%0d got st=%b v=%b exp st=%b",
                 i, a_state, a_rsp_valid, exp_st);
      end
    end
    n_chk++;
    if (a_rsp_instr !== 32'hAAAA_AAAA || a_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_data got %h/%b exp aaaaaaaa/0", a_rsp_instr, a_rsp_err);
    end
    hs_a();
    n_chk++;
    if (a_state !== 2'b00 || a_rsp_valid !== 1'b0 || a_rsp_instr !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL fetch_done got st=%b v=%b i=%h exp 00/0/aaaaaaaa",
               a_state, a_rsp_valid, a_rsp_instr);
    end
  endtask

  task automatic test_backpressure();
    req_a(16'd2);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (a_state !== 2'b10 || a_rsp_valid !== 1'b1 || a_req_ready !== 1'b0
          || a_rsp_instr !== 32'hBBBB_BBBB) begin
        n_fail++;
        $display("FAIL bp_hold%0d got st=%b v=%b r=%b i=%h exp 10/1/0/bbbbbbbb",
                 i, a_state, a_rsp_valid, a_req_ready, a_rsp_instr);
      end
      a_req_valid = (i % 2 == 0); a_req_addr = 16'd0;
      tick();
    end
    a_req_valid = 1'b0;
    n_chk++;
    if (a_state !== 2'b10 || a_rsp_instr !== 32'hBBBB_BBBB) begin
      n_fail++;
      $display("FAIL bp_last got st=%b i=%h exp 10/bbbbbbbb", a_state, a_rsp_instr);
    end
    hs_a();
    n_chk++;
    if (a_state !== 2'b00 || a_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got st=%b v=%b exp 00/0", a_state, a_rsp_valid);
    end
    tick();
    n_chk++;
    if (a_state !== 2'b00 || a_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_single got st=%b v=%b exp 00/0", a_state, a_rsp_valid);
    end
  endtask

  task automatic test_out_of_range();
    load_a(16'd300, 32'h1234_5678);
    req_a(16'd300);
    n_chk++;
    if (a_state !== 2'b10 || a_rsp_instr !== 32'h0 || a_rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_rsp got st=%b i=%h e=%b exp 10/00000000/1",
               a_state, a_rsp_instr, a_rsp_err);
    end
    hs_a();
    req_a(16'd44);
    n_chk++;
    if (a_rsp_instr !== 32'h4444_4444 || a_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_alias got %h/%b exp 44444444/0", a_rsp_instr, a_rsp_err);
    end
    hs_a();
  endtask

  task automatic test_reset_mid();
    a_req_valid = 1'b1; a_req_addr = 16'd0;
    tick();
    a_req_valid = 1'b0;
    tick();
    n_chk++;
    if (a_state !== 2'b01) begin
      n_fail++;
      $display("FAIL rmid_pre got st=%b exp 01", a_state);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (a_state !== 2'b00 || a_busy !== 1'b0 || a_req_ready !== 1'b1
        || a_rsp_instr !== 32'h0 || a_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async got st=%b b=%b r=%b i=%h e=%b exp 00/0/1/0/0",
               a_state, a_busy, a_req_ready, a_rsp_instr, a_rsp_err);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (a_rsp_valid !== 1'b0 || a_state !== 2'b00) begin
        n_fail++;
        $display("FAIL rmid_quiet%0d got v=%b st=%b exp 0/00", i, a_rsp_valid, a_state);
      end
    end
    req_a(16'd0);
    n_chk++;
    if (a_rsp_valid !== 1'b1 || a_rsp_instr !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL rmid_mem got v=%b i=%h exp 1/ffffffff", a_rsp_valid, a_rsp_instr);
    end
    hs_a();
  endtask

  task automatic test_wait0();
    load_b(16'd0, 32'hFFFF_FFFF);
    load_b(16'd2, 32'hBBBB_BBBB);
    b_req_valid = 1'b1; b_req_addr = 16'd0;
    tick();
    b_req_valid = 1'b0;
    n_chk++;
    if (b_state !== 2'b01 || b_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL w0_accept got st=%b v=%b exp 01/0", b_state, b_rsp_valid);
    end
    tick();
    n_chk++;
    if (b_state !== 2'b10 || b_rsp_valid !== 1'b1 || b_rsp_instr !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL w0_rsp got st=%b v=%b i=%h exp 10/1/ffffffff",
               b_state, b_rsp_valid, b_rsp_instr);
    end
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    b_req_valid = 1'b1; b_req_addr = 16'd2;
    tick();
    b_req_valid = 1'b0;
    b_ld_en = 1'b1; b_ld_addr = 16'd2; b_ld_data = 32'hCCCC_CCCC;
    tick();
    b_ld_en = 1'b0;
    n_chk++;
    if (b_state !== 2'b10 || b_rsp_instr !== 32'hBBBB_BBBB) begin
      n_fail++;
      $display("FAIL coll_old got st=%b i=%h exp 10/bbbbbbbb", b_state, b_rsp_instr);
    end
    b_rsp_ready = 1'b1; b_req_valid = 1'b1; b_req_addr = 16'd2;
    tick();
    b_rsp_ready = 1'b0;
    n_chk++;
    if (b_state !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_idle got st=%b exp 00", b_state);
    end
    tick();
    b_req_valid = 1'b0;
    n_chk++;
    if (b_state !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_accept got st=%b exp 01", b_state);
    end
    tick();
    n_chk++;
    if (b_rsp_valid !== 1'b1 || b_rsp_instr !== 32'hCCCC_CCCC) begin
      n_fail++;
      $display("FAIL coll_new got v=%b i=%h exp 1/cccccccc", b_rsp_valid, b_rsp_instr);
    end
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b0;
    a_ld_en = 1'b0; a_ld_addr = '0; a_ld_data = '0;
    b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0;
    b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;
    test_reset();
    test_fetch();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_wait0();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
